// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit accumulator.
//   state_e            : accumulator FSM states
//   BCD_MAX            : largest legal BCD digit value
//   MAX_DIGITS_DEFAULT : default number of decimal digits per entry
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StAdd,
    StCommit
  } state_e;

  localparam int unsigned BCD_MAX            = 9;
  localparam int unsigned MAX_DIGITS_DEFAULT = 3;

endpackage

// File: rtl/bcd_digit_accum.sv
// Collects BCD digits (most significant first) from a keypad-style source and
// converts them to binary with a shift-add multiply-by-10 per digit.
//   CLOCK_50     : clock, rising edge
//   RESET        : asynchronous active-high reset
//   digit        : offered BCD digit
//   digit_valid  : digit is offered this cycle
//   digit_ready  : block accepts a digit this cycle (IDLE only)
//   done         : commit the current entry
//   clear        : abort the current entry (synchronous, highest priority)
//   value        : last committed binary value
//   value_valid  : one-cycle pulse while committing
//   digit_count  : digits held in the current entry
//   bcd_echo     : accepted digits, right-aligned, for a 7-segment display
//   error        : sticky flag for dropped (illegal or overflowing) digits
module bcd_digit_accum
  import bcd_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = MAX_DIGITS_DEFAULT,
  parameter int unsigned VALUE_W    = 10
) (
  input  logic                             CLOCK_50,
  input  logic                             RESET,
  input  logic [3:0]                       digit,
  input  logic                             digit_valid,
  output logic                             digit_ready,
  input  logic                             done,
  input  logic                             clear,
  output logic [VALUE_W-1:0]               value,
  output logic                             value_valid,
  output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count,
  output logic [4*MAX_DIGITS-1:0]          bcd_echo,
  output logic                             error
);

  localparam int unsigned CntW  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned EchoW = 4 * MAX_DIGITS;

  state_e             state_q;
  logic [VALUE_W-1:0] acc_q;
  logic [VALUE_W-1:0] value_q;
  logic [3:0]         digit_q;
  logic [CntW-1:0]    count_q;
  logic [EchoW-1:0]   echo_q;
  logic               error_q;
  logic               ready_q;
  logic               value_valid_q;
  logic               digit_ok;

  // A digit is legal only if it is decimal and the entry still has room.
  assign digit_ok = (digit <= 4'(BCD_MAX)) && (count_q < CntW'(MAX_DIGITS));

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      value_q       <= '0;
      digit_q       <= '0;
      count_q       <= '0;
      echo_q        <= '0;
      error_q       <= 1'b0;
      ready_q       <= 1'b1;
      value_valid_q <= 1'b0;
    end else begin
      value_valid_q <= 1'b0;
      if (clear) begin
        state_q <= StIdle;
        acc_q   <= '0;
        count_q <= '0;
        echo_q  <= '0;
        error_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            // An offered digit always wins over done in the same cycle.
            if (digit_valid) begin
              if (digit_ok) begin
                digit_q <= digit;
                echo_q  <= (echo_q << 4) | EchoW'(digit);
                count_q <= count_q + CntW'(1);
                state_q <= StMul;
                ready_q <= 1'b0;
              end else begin
                error_q <= 1'b1;
              end
            end else if (done && (count_q != '0)) begin
              // value and the pulse are loaded together so they line up in COMMIT.
              value_q       <= acc_q;
              value_valid_q <= 1'b1;
              state_q       <= StCommit;
              ready_q       <= 1'b0;
            end
          end
          StMul: begin
            acc_q   <= (acc_q << 3) + (acc_q << 1);
            state_q <= StAdd;
          end
          StAdd: begin
            acc_q   <= acc_q + VALUE_W'(digit_q);
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
          StCommit: begin
            acc_q   <= '0;
            count_q <= '0;
            echo_q  <= '0;
            error_q <= 1'b0;
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign digit_ready = ready_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign digit_count = count_q;
  assign bcd_echo    = echo_q;
  assign error       = error_q;

endmodule

// File: tb/tb_bcd_digit_accum.sv
// Self-checking bench for bcd_digit_accum: directed scenarios with literal
// expectations, then randomized traffic against a decimal-level model.
module tb_bcd_digit_accum;

  localparam int unsigned MAX_DIGITS = 3;
  localparam int unsigned VALUE_W    = 10;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned ECHO_W     = 12;

  logic                CLOCK_50 = 1'b0;
  logic                RESET = 1'b0;
  logic [3:0]          digit = '0;
  logic                digit_valid = 1'b0;
  logic                done = 1'b0;
  logic                clear = 1'b0;
  logic                digit_ready;
  logic [VALUE_W-1:0]  value;
  logic                value_valid;
  logic [CNT_W-1:0]    digit_count;
  logic [ECHO_W-1:0]   bcd_echo;
  logic                error;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model: the entry is a list of decimal digits; the value is its decimal reading.
  int m_digits[$];
  int m_busy;      // cycles left before a new digit can be taken
  bit m_commit;    // currently in the commit cycle
  bit m_error;
  int m_value;

  bcd_digit_accum #(
    .MAX_DIGITS(MAX_DIGITS),
    .VALUE_W   (VALUE_W)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .digit      (digit),
    .digit_valid(digit_valid),
    .digit_ready(digit_ready),
    .done       (done),
    .clear      (clear),
    .value      (value),
    .value_valid(value_valid),
    .digit_count(digit_count),
    .bcd_echo   (bcd_echo),
    .error      (error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_decimal();
    int v = 0;
    foreach (m_digits[i]) v = (v * 10 + m_digits[i]) % (1 << VALUE_W);
    return v;
  endfunction

  function automatic int m_echo();
    int e = 0;
    foreach (m_digits[i]) e = ((e << 4) | m_digits[i]) & ((1 << ECHO_W) - 1);
    return e;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_busy   = 0;
    m_commit = 1'b0;
    m_error  = 1'b0;
    m_value  = 0;
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_step();
    if (RESET) begin
      model_reset();
    end else if (clear) begin
      m_digits.delete();
      m_busy   = 0;
      m_commit = 1'b0;
      m_error  = 1'b0;
    end else if (m_commit) begin
      m_digits.delete();
      m_error  = 1'b0;
      m_commit = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (digit_valid) begin
      if (digit <= 9 && m_digits.size() < MAX_DIGITS) begin
        m_digits.push_back(int'(digit));
        m_busy = 2;
      end else begin
        m_error = 1'b1;
      end
    end else if (done && m_digits.size() > 0) begin
      m_value  = m_decimal();
      m_commit = 1'b1;
    end
  endtask

  // Single compare process: every cycle, mid-period.
  always @(negedge CLOCK_50) begin
    if (cmp_en) begin
      chk("m_ready", 64'(digit_ready), 64'(!m_commit && m_busy == 0));
      chk("m_count", 64'(digit_count), 64'(m_digits.size()));
      chk("m_echo", 64'(bcd_echo), 64'(m_echo()));
      chk("m_value", 64'(value), 64'(m_value));
      chk("m_vvalid", 64'(value_valid), 64'(m_commit));
      chk("m_error", 64'(error), 64'(m_error));
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    model_step();
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 8 && !digit_ready; i++) tick();
    if (!digit_ready) begin
      failures++;
      checks++;
      $display("FAIL ready_timeout: digit_ready still %0b expected 1", digit_ready);
    end
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit       = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    wait_ready();
  endtask

  task automatic commit();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    model_reset();
    cmp_en = 1'b1;
    RESET  = 1'b1;
    #2;
    chk("rst_ready", 64'(digit_ready), 64'd1);
    chk("rst_value", 64'(value), 64'd0);
    chk("rst_count", 64'(digit_count), 64'd0);
    chk("rst_echo", 64'(bcd_echo), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_vvalid", 64'(value_valid), 64'd0);
    tick();
    tick();
    RESET = 1'b0;
    tick();

    // Held digit_valid: one acceptance, ready low for two cycles.
    digit       = 4'd1;
    digit_valid = 1'b1;
    tick();
    chk("hold_ready_n1", 64'(digit_ready), 64'd0);
    chk("hold_count_n1", 64'(digit_count), 64'd1);
    tick();
    chk("hold_ready_n2", 64'(digit_ready), 64'd0);
    tick();
    chk("hold_ready_n3", 64'(digit_ready), 64'd1);
    chk("hold_count_n3", 64'(digit_count), 64'd1);
    digit_valid = 1'b0;
    commit();
    chk("hold_value", 64'(value), 64'd1);
    tick();

    // 4,0,7 -> 407.
    send_digit(4'd4);
    send_digit(4'd0);
    send_digit(4'd7);
    chk("s407_echo", 64'(bcd_echo), 64'h407);
    chk("s407_count", 64'(digit_count), 64'd3);
    commit();
    chk("s407_vvalid", 64'(value_valid), 64'd1);
    chk("s407_value", 64'(value), 64'd407);
    tick();
    chk("s407_vvalid_off", 64'(value_valid), 64'd0);
    chk("s407_echo_clr", 64'(bcd_echo), 64'd0);
    chk("s407_value_hold", 64'(value), 64'h197);

    // Clear during MUL.
    send_digit(4'd1);
    digit       = 4'd2;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    chk("clr_in_mul", 64'(digit_ready), 64'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_ready", 64'(digit_ready), 64'd1);
    chk("clr_count", 64'(digit_count), 64'd0);
    chk("clr_value", 64'(value), 64'd407);
    chk("clr_vvalid", 64'(value_valid), 64'd0);

    // Illegal digit sets error, then 5 commits and clears it.
    digit       = 4'hA;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    chk("bad_error", 64'(error), 64'd1);
    chk("bad_count", 64'(digit_count), 64'd0);
    chk("bad_ready", 64'(digit_ready), 64'd1);
    send_digit(4'd5);
    commit();
    chk("bad_value", 64'(value), 64'd5);
    tick();
    chk("bad_error_clr", 64'(error), 64'd0);

    // Overflowing fourth digit.
    send_digit(4'd9);
    send_digit(4'd9);
    send_digit(4'd9);
    digit       = 4'd3;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    chk("ovf_error", 64'(error), 64'd1);
    chk("ovf_count", 64'(digit_count), 64'd3);
    chk("ovf_echo", 64'(bcd_echo), 64'h999);
    commit();
    chk("ovf_value", 64'(value), 64'd999);
    tick();
    chk("ovf_error_clr", 64'(error), 64'd0);

    // Reset in the middle of ADD.
    digit       = 4'd3;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    tick();
    RESET = 1'b1;
    model_reset();
    #1;
    chk("rmid_value", 64'(value), 64'd0);
    chk("rmid_ready", 64'(digit_ready), 64'd1);
    chk("rmid_count", 64'(digit_count), 64'd0);
    chk("rmid_vvalid", 64'(value_valid), 64'd0);
    tick();
    RESET = 1'b0;

    // digit and done together: digit wins, no commit.
    digit       = 4'd6;
    digit_valid = 1'b1;
    done        = 1'b1;
    tick();
    digit_valid = 1'b0;
    done        = 1'b0;
    chk("both_count", 64'(digit_count), 64'd1);
    chk("both_ready", 64'(digit_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("both_no_commit", 64'(value_valid), 64'd0);
    end
    chk("both_value", 64'(value), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (RESET) begin
        RESET = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        RESET = 1'b1;
        model_reset();
      end
      digit_valid = 1'($urandom_range(0, 1));
      digit       = 4'($urandom_range(0, 11));
      done        = ($urandom_range(0, 4) == 0);
      clear       = ($urandom_range(0, 39) == 0);
    end
    digit_valid = 1'b0;
    done        = 1'b0;
    clear       = 1'b0;
    tick();
    tick();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
